mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl_pkg.sv | 93 +++++++++
 rtl/mc_ctrl_dec.sv | 40 ++++
 rtl/mc_ctrl.sv | 158 +++++++++++++++
 tb/tb_mc_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: ALU codes, FSM states,
// opcode/funct constants, datapath select values and decode flags.
package mc_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALU_W   = 3;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [ALU_W-1:0] {
    ALU_NOP  = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_SLT  = 3'd5,
    ALU_SLTU = 3'd6,
    ALU_SLL  = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EXE = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  localparam logic [FUNCT_W-1:0] FUNCT_SLL  = 6'b000000;
  localparam logic [FUNCT_W-1:0] FUNCT_JR   = 6'b001000;
  localparam logic [FUNCT_W-1:0] FUNCT_ADD  = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB  = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_AND  = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR   = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT  = 6'b101010;
  localparam logic [FUNCT_W-1:0] FUNCT_SLTU = 6'b101011;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'd0;
  localparam logic [SEL_W-1:0] SRCA_REG   = 2'd1;
  localparam logic [SEL_W-1:0] SRCA_SHAMT = 2'd2;

  localparam logic [SEL_W-1:0] SRCB_REG    = 2'd0;
  localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'd1;
  localparam logic [SEL_W-1:0] SRCB_IMM    = 2'd2;
  localparam logic [SEL_W-1:0] SRCB_IMM_SL = 2'd3;

  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

  localparam logic IORD_PC     = 1'b0;
  localparam logic IORD_ALUOUT = 1'b1;

  localparam logic [SEL_W-1:0] WD_ALUOUT = 2'd0;
  localparam logic [SEL_W-1:0] WD_MDR    = 2'd1;
  localparam logic [SEL_W-1:0] WD_PC     = 2'd2;

  localparam logic [SEL_W-1:0] GPR_RD = 2'd0;
  localparam logic [SEL_W-1:0] GPR_RT = 2'd1;
  localparam logic [SEL_W-1:0] GPR_RA = 2'd2;

  localparam logic [SEL_W-1:0] NPC_ALU    = 2'd0;
  localparam logic [SEL_W-1:0] NPC_ALUOUT = 2'd1;
  localparam logic [SEL_W-1:0] NPC_JUMP   = 2'd2;
  localparam logic [SEL_W-1:0] NPC_REGA   = 2'd3;

  // One-hot instruction class flags; r_alu excludes sll and jr.
  typedef struct packed {
    logic r_alu;
    logic sll;
    logic addi;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
  } dec_t;

  function automatic logic dec_valid(input dec_t d);
    return |d;
  endfunction

endpackage

// File: rtl/mc_ctrl_dec.sv
// Combinational Op/Funct decode into instruction-class flags and the ALU
// operation the instruction needs in its EXE cycle.
module mc_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  output dec_t               dec_c,
  output alu_op_e            exe_alu_op_c
);

  always_comb begin
    dec_c        = '0;
    exe_alu_op_c = ALU_NOP;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FUNCT_ADD:  begin dec_c.r_alu = 1'b1; exe_alu_op_c = ALU_ADD;  end
          FUNCT_SUB:  begin dec_c.r_alu = 1'b1; exe_alu_op_c = ALU_SUB;  end
          FUNCT_AND:  begin dec_c.r_alu = 1'b1; exe_alu_op_c = ALU_AND;  end
          FUNCT_OR:   begin dec_c.r_alu = 1'b1; exe_alu_op_c = ALU_OR;   end
          FUNCT_SLT:  begin dec_c.r_alu = 1'b1; exe_alu_op_c = ALU_SLT;  end
          FUNCT_SLTU: begin dec_c.r_alu = 1'b1; exe_alu_op_c = ALU_SLTU; end
          FUNCT_SLL:  begin dec_c.sll   = 1'b1; exe_alu_op_c = ALU_SLL;  end
          FUNCT_JR:   dec_c.jr = 1'b1;
          default:    ;
        endcase
      end
      OP_ADDI: begin dec_c.addi = 1'b1; exe_alu_op_c = ALU_ADD; end
      OP_ORI:  begin dec_c.ori  = 1'b1; exe_alu_op_c = ALU_OR;  end
      OP_LW:   begin dec_c.lw   = 1'b1; exe_alu_op_c = ALU_ADD; end
      OP_SW:   begin dec_c.sw   = 1'b1; exe_alu_op_c = ALU_ADD; end
      OP_BEQ:  begin dec_c.beq  = 1'b1; exe_alu_op_c = ALU_SUB; end
      OP_J:    dec_c.j   = 1'b1;
      OP_JAL:  dec_c.jal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset controller: IF/ID/EXE/MEM/WB state machine driving
// datapath selects and write enables as a function of the current state.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    Op,
  input  logic [FUNCT_W-1:0] Funct,
  input  logic               Zero,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic [ALU_W-1:0]   ALUOp,
  output logic [SEL_W-1:0]   ALUSrcA,
  output logic [SEL_W-1:0]   ALUSrcB,
  output logic               EXTOp,
  output logic               IorD,
  output logic [SEL_W-1:0]   WDSel,
  output logic [SEL_W-1:0]   GPRSel,
  output logic [SEL_W-1:0]   NPCOp
);

  state_e  state_q, state_d;
  dec_t    dec_c;
  alu_op_e exe_alu_op_c;

  logic              pc_write_c, ir_write_c, reg_write_c, mem_write_c;
  alu_op_e           alu_op_c;
  logic [SEL_W-1:0]  src_a_c, src_b_c, wd_sel_c, gpr_sel_c, npc_op_c;
  logic              ext_op_c, iord_c;

  mc_ctrl_dec u_dec (
    .op           (Op),
    .funct        (Funct),
    .dec_c        (dec_c),
    .exe_alu_op_c (exe_alu_op_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IF;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = ST_IF;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    mem_write_c = 1'b0;
    alu_op_c    = ALU_NOP;
    src_a_c     = SRCA_PC;
    src_b_c     = SRCB_REG;
    ext_op_c    = EXT_ZERO;
    iord_c      = IORD_PC;
    wd_sel_c    = WD_ALUOUT;
    gpr_sel_c   = GPR_RD;
    npc_op_c    = NPC_ALU;

    case (state_q)
      ST_IF: begin
        iord_c     = IORD_PC;
        ir_write_c = 1'b1;
        src_a_c    = SRCA_PC;
        src_b_c    = SRCB_FOUR;
        alu_op_c   = ALU_ADD;
        npc_op_c   = NPC_ALU;
        pc_write_c = 1'b1;
        state_d    = ST_ID;
      end

      ST_ID: begin
        // Branch target is precomputed into ALUOut for every instruction.
        src_a_c  = SRCA_PC;
        src_b_c  = SRCB_IMM_SL;
        ext_op_c = EXT_SIGN;
        alu_op_c = ALU_ADD;
        if (dec_c.j) begin
          pc_write_c = 1'b1;
          npc_op_c   = NPC_JUMP;
        end else if (dec_c.jal) begin
          pc_write_c  = 1'b1;
          npc_op_c    = NPC_JUMP;
          reg_write_c = 1'b1;
          gpr_sel_c   = GPR_RA;
          wd_sel_c    = WD_PC;
        end else if (dec_c.jr) begin
          pc_write_c = 1'b1;
          npc_op_c   = NPC_REGA;
        end else if (dec_valid(dec_c)) begin
          state_d = ST_EXE;
        end
      end

      ST_EXE: begin
        alu_op_c = exe_alu_op_c;
        if (dec_c.r_alu) begin
          src_a_c = SRCA_REG;
          src_b_c = SRCB_REG;
          state_d = ST_WB;
        end else if (dec_c.sll) begin
          src_a_c = SRCA_SHAMT;
          src_b_c = SRCB_REG;
          state_d = ST_WB;
        end else if (dec_c.addi || dec_c.ori) begin
          src_a_c  = SRCA_REG;
          src_b_c  = SRCB_IMM;
          ext_op_c = dec_c.addi ? EXT_SIGN : EXT_ZERO;
          state_d  = ST_WB;
        end else if (dec_c.lw || dec_c.sw) begin
          src_a_c  = SRCA_REG;
          src_b_c  = SRCB_IMM;
          ext_op_c = EXT_SIGN;
          state_d  = ST_MEM;
        end else if (dec_c.beq) begin
          src_a_c    = SRCA_REG;
          src_b_c    = SRCB_REG;
          pc_write_c = Zero;
          npc_op_c   = NPC_ALUOUT;
        end
      end

      ST_MEM: begin
        iord_c      = IORD_ALUOUT;
        mem_write_c = dec_c.sw;
        if (dec_c.lw) state_d = ST_WB;
      end

      ST_WB: begin
        reg_write_c = 1'b1;
        if (dec_c.lw) begin
          wd_sel_c  = WD_MDR;
          gpr_sel_c = GPR_RT;
        end else if (dec_c.addi || dec_c.ori) begin
          gpr_sel_c = GPR_RT;
        end
      end

      default: state_d = ST_IF;
    endcase
  end

  // Reset masks write enables so an aborted instruction leaves no partial write.
  assign PCWrite  = pc_write_c  & rst;
  assign IRWrite  = ir_write_c  & rst;
  assign RegWrite = reg_write_c & rst;
  assign MemWrite = mem_write_c & rst;
  assign ALUOp    = alu_op_c;
  assign ALUSrcA  = src_a_c;
  assign ALUSrcB  = src_b_c;
  assign EXTOp    = ext_op_c;
  assign IorD     = iord_c;
  assign WDSel    = wd_sel_c;
  assign GPRSel   = gpr_sel_c;
  assign NPCOp    = npc_op_c;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: a per-instruction reference model queues the
// expected per-cycle control word; a negedge monitor pops and compares.
module tb_mc_ctrl;

  typedef struct packed {
    logic       pcw;
    logic       irw;
    logic       regw;
    logic       memw;
    logic [2:0] alu;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic       ext;
    logic       iord;
    logic [1:0] wd;
    logic [1:0] gpr;
    logic [1:0] npc;
  } out_t;

  logic       clk;
  logic       rst;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCWrite, IRWrite, RegWrite, MemWrite;
  logic [2:0] ALUOp;
  logic [1:0] ALUSrcA, ALUSrcB;
  logic       EXTOp, IorD;
  logic [1:0] WDSel, GPRSel, NPCOp;

  int    total = 0;
  int    bad   = 0;
  bit    mon_en = 1'b0;
  out_t  exp_q[$];
  string tag_q[$];

  mc_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .Op       (Op),
    .Funct    (Funct),
    .Zero     (Zero),
    .PCWrite  (PCWrite),
    .IRWrite  (IRWrite),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .ALUOp    (ALUOp),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .EXTOp    (EXTOp),
    .IorD     (IorD),
    .WDSel    (WDSel),
    .GPRSel   (GPRSel),
    .NPCOp    (NPCOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t pack_out();
    out_t o;
    o.pcw  = PCWrite;
    o.irw  = IRWrite;
    o.regw = RegWrite;
    o.memw = MemWrite;
    o.alu  = ALUOp;
    o.srca = ALUSrcA;
    o.srcb = ALUSrcB;
    o.ext  = EXTOp;
    o.iord = IorD;
    o.wd   = WDSel;
    o.gpr  = GPRSel;
    o.npc  = NPCOp;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%05h exp=%05h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the control words one instruction produces, cycle by cycle.
  task automatic expect_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                              input int limit, output int n);
    string kind;
    out_t  seq[$];
    out_t  w;
    kind = "bad";
    case (op)
      6'b000000: case (fn)
        6'b100000: kind = "add";
        6'b100010: kind = "sub";
        6'b100100: kind = "and";
        6'b100101: kind = "or";
        6'b101010: kind = "slt";
        6'b101011: kind = "sltu";
        6'b000000: kind = "sll";
        6'b001000: kind = "jr";
        default:   kind = "bad";
      endcase
      6'b001000: kind = "addi";
      6'b001101: kind = "ori";
      6'b100011: kind = "lw";
      6'b101011: kind = "sw";
      6'b000100: kind = "beq";
      6'b000010: kind = "j";
      6'b000011: kind = "jal";
      default:   kind = "bad";
    endcase

    // fetch: IR <= mem[PC], PC <= PC + 4
    w = '0; w.pcw = 1; w.irw = 1; w.alu = 3'd1; w.srcb = 2'd1;
    seq.push_back(w);

    // decode: ALUOut <= PC + (sext imm << 2); jumps finish here
    w = '0; w.alu = 3'd1; w.srcb = 2'd3; w.ext = 1;
    if (kind == "j")   begin w.pcw = 1; w.npc = 2'd2; end
    if (kind == "jal") begin w.pcw = 1; w.npc = 2'd2; w.regw = 1; w.gpr = 2'd2; w.wd = 2'd2; end
    if (kind == "jr")  begin w.pcw = 1; w.npc = 2'd3; end
    seq.push_back(w);

    if (!(kind == "j" || kind == "jal" || kind == "jr" || kind == "bad")) begin
      w = '0;
      case (kind)
        "add":  begin w.srca = 1; w.alu = 3'd1; end
        "sub":  begin w.srca = 1; w.alu = 3'd2; end
        "and":  begin w.srca = 1; w.alu = 3'd3; end
        "or":   begin w.srca = 1; w.alu = 3'd4; end
        "slt":  begin w.srca = 1; w.alu = 3'd5; end
        "sltu": begin w.srca = 1; w.alu = 3'd6; end
        "sll":  begin w.srca = 2; w.alu = 3'd7; end
        "addi": begin w.srca = 1; w.srcb = 2; w.ext = 1; w.alu = 3'd1; end
        "ori":  begin w.srca = 1; w.srcb = 2; w.alu = 3'd4; end
        "lw", "sw": begin w.srca = 1; w.srcb = 2; w.ext = 1; w.alu = 3'd1; end
        "beq":  begin w.srca = 1; w.alu = 3'd2; w.pcw = z; w.npc = 2'd1; end
        default: ;
      endcase
      seq.push_back(w);

      if (kind == "lw" || kind == "sw") begin
        w = '0; w.iord = 1; w.memw = (kind == "sw");
        seq.push_back(w);
      end

      if (kind != "beq" && kind != "sw") begin
        w = '0; w.regw = 1;
        w.wd  = (kind == "lw") ? 2'd1 : 2'd0;
        w.gpr = (kind == "lw" || kind == "addi" || kind == "ori") ? 2'd1 : 2'd0;
        seq.push_back(w);
      end
    end

    n = 0;
    foreach (seq[i]) begin
      if (i < limit) begin
        exp_q.push_back(seq[i]);
        tag_q.push_back($sformatf("%s_op%02h_fn%02h_c%0d", kind, op, fn, i));
        n++;
      end
    end
  endtask

  // Called just after a rising edge with the DUT about to fetch.
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z);
    int n;
    Op = op; Funct = fn; Zero = z;
    expect_instr(op, fn, z, 99, n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty got=%05h exp=none at %0t", 32'(pack_out()), $time);
      end else begin
        out_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, 32'(pack_out()), 32'(e));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  localparam logic [11:0] TBL [14] = '{
    {6'b000000, 6'b100000}, {6'b000000, 6'b100010}, {6'b000000, 6'b100100},
    {6'b000000, 6'b100101}, {6'b000000, 6'b101010}, {6'b000000, 6'b101011},
    {6'b000000, 6'b000000}, {6'b000000, 6'b001000}, {6'b001000, 6'b000000},
    {6'b001101, 6'b000000}, {6'b100011, 6'b000000}, {6'b101011, 6'b000000},
    {6'b000100, 6'b000000}, {6'b000011, 6'b000000}
  };

  initial begin
    out_t idle;
    int   n;
    logic [11:0] ent;
    rst = 1'b0; Op = '0; Funct = '0; Zero = 1'b0;

    // Held in reset: fetch-state selects, every write enable masked.
    idle = '0; idle.alu = 3'd1; idle.srcb = 2'd1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(pack_out()), 32'(idle));
    check("reset_we", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'(0));

    rst = 1'b1;
    mon_en = 1'b1;

    run(6'b000000, 6'b100000, 1'b0);  // add
    run(6'b000000, 6'b000000, 1'b0);  // sll
    run(6'b000100, 6'b000000, 1'b1);  // beq taken
    run(6'b000100, 6'b000000, 1'b0);  // beq not taken
    run(6'b100011, 6'b000000, 1'b0);  // lw
    run(6'b101011, 6'b000000, 1'b0);  // sw
    run(6'b000011, 6'b000000, 1'b0);  // jal
    run(6'b000010, 6'b000000, 1'b0);  // j
    run(6'b000000, 6'b001000, 1'b0);  // jr
    run(6'b111111, 6'b000000, 1'b0);  // undecoded op
    run(6'b000000, 6'b111111, 1'b0);  // undecoded funct
    run(6'b001000, 6'b000000, 1'b0);  // addi
    run(6'b001101, 6'b000000, 1'b1);  // ori

    // Abort lw while it sits in MEM.
    Op = 6'b100011; Funct = '0; Zero = 1'b0;
    expect_instr(6'b100011, 6'b000000, 1'b0, 4, n);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    check("abort_to_if", 32'(pack_out()), 32'(idle));
    @(posedge clk);
    #1;
    check("abort_hold_no_we", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'(0));
    rst = 1'b1;
    mon_en = 1'b1;
    run(6'b100011, 6'b000000, 1'b1);  // lw after abort

    for (int k = 0; k < 300; k++) begin
      int sel;
      sel = $urandom_range(0, 17);
      if (sel < 14) begin
        ent = TBL[sel];
        run(ent[11:6], ent[5:0], 1'($urandom_range(0, 1)));
      end else if (sel < 16) begin
        run(6'($urandom), 6'($urandom), 1'($urandom_range(0, 1)));
      end else begin
        run(6'b000000, 6'($urandom), 1'($urandom_range(0, 1)));
      end
    end

    mon_en = 1'b0;
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
